// File: rtl/timer_decoder.sv
// timer_decoder: MM:SS cook timer fed by the keypad encoder.
// BCD digits strobed by loadn shift into a four-digit entry register.
// pgt_1hz ticks count the entry down while a start/pause/stop FSM is in COUNT.
// All four digits are decoded to seven-segment patterns.
// state_dbg exposes the FSM state for observation.
//
// Handshake: loadn is a data-valid strobe with no ready/backpressure.
// One digit is accepted on the clock edge where loadn is first seen low,
// and BCD_IN is sampled on that same edge.
// Holding loadn low does not load again; loadn must return high before the next digit.
module timer_decoder #(
  parameter bit         SEG_ACTIVE_LOW = 1'b0,
  parameter logic [3:0] SEC_TENS_WRAP  = 4'd5
) (
  input  logic        clk,
  input  logic        clearn,
  input  logic [3:0]  BCD_IN,
  input  logic        loadn,
  input  logic        pgt_1hz,
  input  logic        startn,
  input  logic        stopn,
  input  logic        door_closed,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic [27:0] seg,
  output logic        mag_on,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // {min_tens, min_ones, sec_tens, sec_ones}
  logic        loadn_q, loadn_d;
  logic        tick_q, tick_d;
  logic        mag_on_q, mag_on_d;
  logic        done_q, done_d;

  logic        load_ev;
  logic        tick_ev;
  logic        load_ok;
  logic [15:0] shift_val;
  logic [15:0] dec_val;
  logic        cnt_zero;
  logic        dec_zero;

  // Decrement datapath digits and the borrow chain between them.
  logic [3:0]  dec_so, dec_st, dec_mo, dec_mt;
  logic        b_so, b_st, b_mo;

  // Edge detectors: the _q copies of loadn and pgt_1hz are sampled every clock.
  always_comb begin
    loadn_d = loadn;
    tick_d  = pgt_1hz;
    load_ev = loadn_q & ~loadn;
    tick_ev = ~tick_q & pgt_1hz;
  end

  // Shift-in value for a digit load; digits above 9 are rejected here.
  always_comb begin
    shift_val = {cnt_q[11:0], BCD_IN};
    load_ok   = load_ev && (BCD_IN <= 4'd9);
    cnt_zero  = (cnt_q == 16'h0000);
  end

  // One-second BCD decrement with borrow.
  // sec_tens wraps to SEC_TENS_WRAP, so seconds roll from 00 to 59.
  always_comb begin
    dec_so = cnt_q[3:0];
    dec_st = cnt_q[7:4];
    dec_mo = cnt_q[11:8];
    dec_mt = cnt_q[15:12];
    b_so   = 1'b0;
    b_st   = 1'b0;
    b_mo   = 1'b0;
    if (cnt_q[3:0] == 4'd0) begin
      dec_so = 4'd9;
      b_so   = 1'b1;
    end else begin
      dec_so = cnt_q[3:0] - 4'd1;
    end
    if (b_so) begin
      if (cnt_q[7:4] == 4'd0) begin
        dec_st = SEC_TENS_WRAP;
        b_st   = 1'b1;
      end else begin
        dec_st = cnt_q[7:4] - 4'd1;
      end
    end
    if (b_st) begin
      if (cnt_q[11:8] == 4'd0) begin
        dec_mo = 4'd9;
        b_mo   = 1'b1;
      end else begin
        dec_mo = cnt_q[11:8] - 4'd1;
      end
    end
    if (b_mo) begin
      dec_mt = cnt_q[15:12] - 4'd1;
    end
    dec_val  = {dec_mt, dec_mo, dec_st, dec_so};
    dec_zero = (dec_val == 16'h0000);
  end

  // FSM next state and digit-register update.
  // Within each state, stop has the highest priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!stopn) begin
          cnt_d = 16'h0000;
        end else if (!startn && door_closed && !cnt_zero) begin
          state_d = ST_COUNT;
        end else if (load_ok) begin
          cnt_d = shift_val;
        end
      end
      ST_COUNT: begin
        if (!stopn || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick_ev && !cnt_zero) begin
          cnt_d = dec_val;
          if (dec_zero) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (!stopn) begin
          state_d = ST_IDLE;
          cnt_d   = 16'h0000;
        end else if (!startn && door_closed) begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        if (!stopn) begin
          state_d = ST_IDLE;
          cnt_d   = 16'h0000;
        end else if (load_ok) begin
          state_d = ST_IDLE;
          cnt_d   = shift_val;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'h0000;
      end
    endcase
    mag_on_d = (state_d == ST_COUNT);
    done_d   = (state_d == ST_DONE);
  end

  // State, digit, edge-detect and status registers.
  // Clearing asynchronously drops mag_on at once.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'h0000;
      loadn_q  <= 1'b1;
      tick_q   <= 1'b1;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loadn_q  <= loadn_d;
      tick_q   <= tick_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  // Seven-segment decode, gfedcba order; codes above 9 are blanked.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Drive the outputs from the registers; seg polarity is set by SEG_ACTIVE_LOW.
  always_comb begin
    min_tens  = cnt_q[15:12];
    min_ones  = cnt_q[11:8];
    sec_tens  = cnt_q[7:4];
    sec_ones  = cnt_q[3:0];
    seg       = {seg7(cnt_q[15:12]), seg7(cnt_q[11:8]),
                 seg7(cnt_q[7:4]), seg7(cnt_q[3:0])} ^ {28{SEG_ACTIVE_LOW}};
    mag_on    = mag_on_q;
    done      = done_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_timer_decoder.sv
// Testbench for timer_decoder.
// The model keeps minutes and seconds as plain integers plus a state code.
// Each action pushes its expected outputs into exp_q.
// After the clock edge the entry is popped and compared with the DUT outputs.
module tb_timer_decoder;

  localparam int W = 48;  // {digits16, mag_on, done, state2, seg28}

  logic        clk;
  logic        clearn;
  logic [3:0]  bcd_in;
  logic        loadn;
  logic        pgt_1hz;
  logic        startn;
  logic        stopn;
  logic        door_closed;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic [27:0] seg;
  logic        mag_on;
  logic        done;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];

  int n_compared;
  int n_mismatched;

  // Model state: 0 IDLE, 1 COUNT, 2 PAUSE, 3 DONE.
  int m_mm;
  int m_ss;
  int m_state;

  timer_decoder #(.SEG_ACTIVE_LOW(1'b0), .SEC_TENS_WRAP(4'd5)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .BCD_IN      (bcd_in),
    .loadn       (loadn),
    .pgt_1hz     (pgt_1hz),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .seg         (seg),
    .mag_on      (mag_on),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t[10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  function automatic logic [W-1:0] model_pack();
    logic [15:0] dg;
    logic [27:0] sg;
    dg = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    sg = {seg_ref(m_mm / 10), seg_ref(m_mm % 10), seg_ref(m_ss / 10), seg_ref(m_ss % 10)};
    return {dg, (m_state == 1), (m_state == 3), 2'(m_state), sg};
  endfunction

  task automatic push_expected();
    exp_q.push_back(model_pack());
  endtask

  task automatic pop_compare(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] o;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    o = {min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state_dbg, seg};
    check({tag, "_state"}, 64'(o[W-1:28]), 64'(e[W-1:28]));
    check({tag, "_seg"}, 64'(o[27:0]), 64'(e[27:0]));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks: each one drives a stimulus, updates the model, then compares.
  task automatic load_digit(input logic [3:0] d, input string tag);
    int v;
    loadn  = 1'b0;
    bcd_in = d;
    if ((m_state == 0 || m_state == 3) && d <= 4'd9) begin
      v       = ((m_mm * 100 + m_ss) * 10 + int'(d)) % 10000;
      m_mm    = v / 100;
      m_ss    = v % 100;
      m_state = 0;
    end
    push_expected();
    step();
    pop_compare(tag);
    loadn  = 1'b1;
    bcd_in = 4'($urandom_range(0, 15));
    step();
  endtask

  task automatic tick(input logic door, input string tag);
    pgt_1hz     = 1'b1;
    door_closed = door;
    if (m_state == 1) begin
      if (!door) begin
        m_state = 2;
      end else if (m_mm != 0 || m_ss != 0) begin
        if (m_ss > 0) begin
          m_ss--;
        end else begin
          m_mm--;
          m_ss = 59;
        end
        if (m_mm == 0 && m_ss == 0) m_state = 3;
      end
    end
    push_expected();
    step();
    pop_compare(tag);
    pgt_1hz     = 1'b0;
    door_closed = 1'b1;
    step();
  endtask

  task automatic press_start(input string tag);
    startn = 1'b0;
    if (m_state == 0 && door_closed && (m_mm != 0 || m_ss != 0)) m_state = 1;
    else if (m_state == 2 && door_closed) m_state = 1;
    push_expected();
    step();
    pop_compare(tag);
    startn = 1'b1;
    step();
  endtask

  task automatic press_stop(input string tag);
    stopn = 1'b0;
    if (m_state == 1) begin
      m_state = 2;
    end else begin
      m_state = 0;
      m_mm    = 0;
      m_ss    = 0;
    end
    push_expected();
    step();
    pop_compare(tag);
    stopn = 1'b1;
    step();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clearn      = 1'b0;
    bcd_in      = 4'd0;
    loadn       = 1'b1;
    pgt_1hz     = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    m_mm = 0; m_ss = 0; m_state = 0;

    // Reset state.
    #12;
    push_expected();
    pop_compare("reset");
    @(negedge clk);
    clearn = 1'b1;
    step();

    // Entry: 00:01, 00:13, 01:30.
    load_digit(4'd1, "load_1");
    load_digit(4'd3, "load_3");
    load_digit(4'd0, "load_0");

    // Start, then three ticks down to 01:27.
    press_start("start_130");
    for (int i = 0; i < 3; i++) tick(1'b1, "tick_first3");

    // Count down to 00:00, including the 01:00 -> 00:59 borrow.
    for (int i = 0; i < 200 && m_state == 1; i++) tick(1'b1, "tick_run");
    check("reached_done", 64'(m_state), 64'd3);

    // A load in DONE returns to IDLE with 00:05.
    load_digit(4'd5, "load_in_done");
    load_digit(4'd2, "load_52");
    press_start("start_52");

    // Door opened on the tick cycle pauses with no decrement; ticks are ignored in PAUSE.
    tick(1'b0, "tick_door_open");
    tick(1'b1, "tick_in_pause");
    press_start("resume");
    tick(1'b1, "tick_after_resume");

    // Stop pauses, a second stop clears, and start at 00:00 is ignored.
    press_stop("stop_in_count");
    press_stop("stop_in_pause");
    press_start("start_at_zero");
    load_digit(4'hC, "load_invalid");
    load_digit(4'd7, "load_7");
    press_stop("stop_in_idle");

    // A 90 s entry counts linearly; a load during COUNT is ignored.
    load_digit(4'd9, "load_9");
    load_digit(4'd0, "load_90");
    press_start("start_90");
    load_digit(4'd3, "load_in_count");
    tick(1'b1, "tick_90");

    // Asynchronous clear in the middle of COUNT.
    #2;
    clearn = 1'b0;
    m_mm = 0; m_ss = 0; m_state = 0;
    #1;
    push_expected();
    pop_compare("async_clear");
    step();
    clearn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
